// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared definitions for the CORDIC vectoring initiator:
//   default widths and run length, the angle constant for pi, and the
//   sequencer state encoding.
package cordic_pkg;

   localparam int C_DATA_W  = 16;   // signed width of x, y and magnitude
   localparam int C_ANGLE_W = 16;   // angle width, full scale = 2*pi
   localparam int C_LATENCY = 17;   // core enable length, start cycle included

   // pi in angle units at the default angle width
   localparam logic [C_ANGLE_W-1:0] C_ANGLE_PI = {1'b1, {(C_ANGLE_W-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_HOLD    = 3'd4
   } seq_state_t;

endpackage

// File: rtl/cordic_prerotate.sv
// cordic_prerotate
//   Combinational fold of an (x, y) sample into the right half-plane so
//   the vectoring core only sees angles within +/-pi/2.
//   Ports:
//     i_x, i_y     signed input sample
//     o_x, o_y     folded sample (negated when x < 0, saturating)
//     o_offset     angle to add back to the core result (0 or pi)
module cordic_prerotate
   import cordic_pkg::*;
#(
   parameter int DATA_W  = C_DATA_W,
   parameter int ANGLE_W = C_ANGLE_W
)(
   input  logic signed [DATA_W-1:0]  i_x,
   input  logic signed [DATA_W-1:0]  i_y,
   output logic signed [DATA_W-1:0]  o_x,
   output logic signed [DATA_W-1:0]  o_y,
   output logic        [ANGLE_W-1:0] o_offset
);

   localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [ANGLE_W-1:0]       PI_VAL  = {1'b1, {(ANGLE_W-1){1'b0}}};

   logic w_neg;

   assign w_neg = i_x[DATA_W-1];

   // Rotate by pi when x is negative; the most negative code has no
   // positive twin, so it clamps to the largest positive value.
   always_comb begin
      o_x      = i_x;
      o_y      = i_y;
      o_offset = {ANGLE_W{1'b0}};
      if (w_neg) begin
         o_x      = (i_x == MIN_VAL) ? MAX_VAL : -i_x;
         o_y      = (i_y == MIN_VAL) ? MAX_VAL : -i_y;
         o_offset = PI_VAL;
      end else begin
         o_x      = i_x;
         o_y      = i_y;
         o_offset = {ANGLE_W{1'b0}};
      end
   end

endmodule

// File: rtl/cordic_sequencer.sv
// cordic_sequencer
//   Initiator for the iterative CORDIC vectoring core. Accepts a sample,
//   folds it into the right half-plane, pulses the core start, waits out
//   the fixed run length, captures magnitude and angle, restores the
//   folded half-plane and holds the result until the consumer takes it.
//   Ports:
//     i_clock, i_reset              clock, synchronous active-high reset
//     i_in_valid/o_in_ready         sample handshake, i_in_x/i_in_y data
//     o_cordic_start                one-cycle start pulse to the core
//     o_cordic_x/o_cordic_y         folded operands held for the whole run
//     i_cordic_mag/i_cordic_angle   core results
//     o_out_valid/i_out_ready       result handshake
//     o_out_mag/o_out_angle         magnitude, full-circle angle (mod 2*pi)
module cordic_sequencer
   import cordic_pkg::*;
#(
   parameter int DATA_W  = C_DATA_W,
   parameter int ANGLE_W = C_ANGLE_W,
   parameter int LATENCY = C_LATENCY
)(
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_in_valid,
   output logic                      o_in_ready,
   input  logic signed [DATA_W-1:0]  i_in_x,
   input  logic signed [DATA_W-1:0]  i_in_y,
   output logic                      o_cordic_start,
   output logic signed [DATA_W-1:0]  o_cordic_x,
   output logic signed [DATA_W-1:0]  o_cordic_y,
   input  logic        [DATA_W-1:0]  i_cordic_mag,
   input  logic        [ANGLE_W-1:0] i_cordic_angle,
   output logic                      o_out_valid,
   input  logic                      i_out_ready,
   output logic        [DATA_W-1:0]  o_out_mag,
   output logic        [ANGLE_W-1:0] o_out_angle
);

   localparam int               CNT_W    = $clog2(LATENCY);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

   seq_state_t                r_state;
   logic                      r_in_ready;
   logic                      r_start;
   logic signed [DATA_W-1:0]  r_cx;
   logic signed [DATA_W-1:0]  r_cy;
   logic        [ANGLE_W-1:0] r_offset;
   logic        [CNT_W-1:0]   r_cnt;
   logic                      r_out_valid;
   logic        [DATA_W-1:0]  r_mag;
   logic        [ANGLE_W-1:0] r_angle;

   logic signed [DATA_W-1:0]  w_fold_x;
   logic signed [DATA_W-1:0]  w_fold_y;
   logic        [ANGLE_W-1:0] w_fold_off;

   cordic_prerotate #(
      .DATA_W  (DATA_W),
      .ANGLE_W (ANGLE_W)
   ) u_prerotate (
      .i_x      (i_in_x),
      .i_y      (i_in_y),
      .o_x      (w_fold_x),
      .o_y      (w_fold_y),
      .o_offset (w_fold_off)
   );

   // Sequencer FSM with all handshake and datapath outputs registered.
   // r_cnt numbers the core enable cycles with the start cycle as 0, so
   // reaching LATENCY-1 marks the last enable cycle and the core result
   // is present during the following CAPTURE cycle.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_start     <= 1'b0;
         r_cx        <= {DATA_W{1'b0}};
         r_cy        <= {DATA_W{1'b0}};
         r_offset    <= {ANGLE_W{1'b0}};
         r_cnt       <= {CNT_W{1'b0}};
         r_out_valid <= 1'b0;
         r_mag       <= {DATA_W{1'b0}};
         r_angle     <= {ANGLE_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_in_valid && r_in_ready) begin
                  r_cx       <= w_fold_x;
                  r_cy       <= w_fold_y;
                  r_offset   <= w_fold_off;
                  r_cnt      <= {CNT_W{1'b0}};
                  r_start    <= 1'b1;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_START;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            ST_START: begin
               r_start <= 1'b0;
               r_cnt   <= r_cnt + CNT_ONE;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (r_cnt == CNT_LAST) begin
                  r_state <= ST_CAPTURE;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            ST_CAPTURE: begin
               r_mag       <= i_cordic_mag;
               // modular add: wraps past +pi by design
               r_angle     <= i_cordic_angle + r_offset;
               r_cnt       <= {CNT_W{1'b0}};
               r_out_valid <= 1'b1;
               r_state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end else begin
                  r_out_valid <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b0;
               r_start     <= 1'b0;
               r_out_valid <= 1'b0;
               r_cnt       <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign o_in_ready     = r_in_ready;
   assign o_cordic_start = r_start;
   assign o_cordic_x     = r_cx;
   assign o_cordic_y     = r_cy;
   assign o_out_valid    = r_out_valid;
   assign o_out_mag      = r_mag;
   assign o_out_angle    = r_angle;

endmodule

// File: tb/tb_cordic_sequencer.sv
module tb_cordic_sequencer;

   localparam int LAT = 17;
   localparam real M_PI = 3.14159265358979323846;

   logic               clk = 1'b0;
   logic               i_reset;
   logic               i_in_valid;
   logic               o_in_ready;
   logic signed [15:0] i_in_x;
   logic signed [15:0] i_in_y;
   logic               o_cordic_start;
   logic signed [15:0] o_cordic_x;
   logic signed [15:0] o_cordic_y;
   logic        [15:0] i_cordic_mag;
   logic        [15:0] i_cordic_angle;
   logic               o_out_valid;
   logic               i_out_ready;
   logic        [15:0] o_out_mag;
   logic        [15:0] o_out_angle;

   int total = 0;
   int bad   = 0;

   // core model state
   int                 k      = 0;
   int                 starts = 0;
   logic signed [15:0] run_x  = 16'sd0;
   logic signed [15:0] run_y  = 16'sd0;

   always #5 clk = ~clk;

   cordic_sequencer dut (
      .i_clock        (clk),
      .i_reset        (i_reset),
      .i_in_valid     (i_in_valid),
      .o_in_ready     (o_in_ready),
      .i_in_x         (i_in_x),
      .i_in_y         (i_in_y),
      .o_cordic_start (o_cordic_start),
      .o_cordic_x     (o_cordic_x),
      .o_cordic_y     (o_cordic_y),
      .i_cordic_mag   (i_cordic_mag),
      .i_cordic_angle (i_cordic_angle),
      .o_out_valid    (o_out_valid),
      .i_out_ready    (i_out_ready),
      .o_out_mag      (o_out_mag),
      .o_out_angle    (o_out_angle)
   );

   // ---------------- math reference ----------------
   function automatic int round_r(input real v);
      return $rtoi($floor(v + 0.5));
   endfunction

   // angle of (x, y) in units where 2*pi = 65536, taken mod 2^16
   function automatic logic [15:0] angle_of(input int x, input int y);
      int r;
      r = round_r($atan2(real'(y), real'(x)) * 65536.0 / (2.0 * M_PI));
      return r[15:0];
   endfunction

   function automatic logic [15:0] mag_of(input int x, input int y);
      int r;
      r = round_r($sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
      if (r > 32767) r = 32767;
      return r[15:0];
   endfunction

   // ---------------- comparison helpers ----------------
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_near(input string name, input logic [15:0] act, input logic [15:0] exp);
      logic [15:0] d;
      d = act - exp;
      total++;
      if (!(d == 16'h0000 || d == 16'h0001 || d == 16'hFFFF)) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (+/-1)", name, act, exp);
      end
   endtask

   // ---------------- behavioural core ----------------
   // Result only valid in the cycle LAT after the start cycle; junk otherwise.
   always @(posedge clk) begin
      if (i_reset) k = 0;
      else if (o_cordic_start) begin
         k = 1;
         starts = starts + 1;
         run_x = o_cordic_x;
         run_y = o_cordic_y;
      end
      else if (k != 0 && k <= LAT) k = k + 1;
      else k = 0;
      #1;
      if (k >= 1 && k <= LAT) begin
         total++;
         if (o_cordic_x !== run_x || o_cordic_y !== run_y) begin
            bad++;
            $display("FAIL operand_hold: got %0h/%0h expected %0h/%0h", o_cordic_x, o_cordic_y, run_x, run_y);
         end
      end
      if (k == LAT) begin
         i_cordic_angle = angle_of(int'(o_cordic_x), int'(o_cordic_y));
         i_cordic_mag   = mag_of(int'(o_cordic_x), int'(o_cordic_y));
      end else begin
         i_cordic_angle = 16'($urandom);
         i_cordic_mag   = 16'($urandom);
      end
   end

   // ---------------- single transaction ----------------
   task automatic run_one(input int x, input int y, input int ex, input int ey,
                          input int eang, input int emag, input int hold);
      int n;
      int s0;
      @(negedge clk);
      i_in_x      = 16'(x);
      i_in_y      = 16'(y);
      i_in_valid  = 1'b1;
      i_out_ready = (hold == 0);
      n = 0;
      while (!o_in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", {15'd0, o_in_ready}, 16'd1);
      s0 = starts;
      @(posedge clk);
      #1;
      i_in_valid = 1'b0;
      i_in_x     = 16'($urandom);
      i_in_y     = 16'($urandom);
      @(negedge clk);
      check("start_t1", {15'd0, o_cordic_start}, 16'd1);
      check("ready_low_t1", {15'd0, o_in_ready}, 16'd0);
      check("cordic_x", o_cordic_x, 16'(ex));
      check("cordic_y", o_cordic_y, 16'(ey));
      n = 1;
      while (!o_out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("latency", 16'(n), 16'(LAT + 2));
      check("out_mag", o_out_mag, 16'(emag));
      check("out_angle", o_out_angle, 16'(eang));
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            i_in_valid = 1'b1;
            i_in_x     = 16'($urandom);
            i_in_y     = 16'($urandom);
            @(negedge clk);
            check("hold_valid", {15'd0, o_out_valid}, 16'd1);
            check("hold_ready", {15'd0, o_in_ready}, 16'd0);
            check("hold_mag", o_out_mag, 16'(emag));
            check("hold_angle", o_out_angle, 16'(eang));
         end
         i_in_valid  = 1'b0;
         i_out_ready = 1'b1;
      end
      @(negedge clk);
      check("h1_valid", {15'd0, o_out_valid}, 16'd0);
      check("h1_ready", {15'd0, o_in_ready}, 16'd1);
      check("start_count", 16'(starts - s0), 16'd1);
   endtask

   typedef struct {
      int x;
      int y;
      int ex;
      int ey;
      int eang;
      int emag;
   } vec_t;

   vec_t tv[11];

   initial begin
      int last_start;
      int ncyc;
      int pushed;
      int popped;
      int s0;
      int qx[$];
      int qy[$];
      int rx;
      int ry;

      tv[0]  = '{1000,      0,  1000,     0, 'h0000,  1000};
      tv[1]  = '{-1000,     0,  1000,     0, 'h8000,  1000};
      tv[2]  = '{-1000, -1000,  1000,  1000, 'hA000,  1414};
      tv[3]  = '{-32768,    0, 32767,     0, 'h8000, 32767};
      tv[4]  = '{-32768,-32768, 32767, 32767, 'hA000, 32767};
      tv[5]  = '{0,       500,     0,   500, 'h4000,   500};
      tv[6]  = '{0,      -500,     0,  -500, 'hC000,   500};
      tv[7]  = '{-1,        1,     1,    -1, 'h6000,     1};
      tv[8]  = '{300,    -300,   300,  -300, 'hE000,   424};
      tv[9]  = '{-1000,  1000,  1000, -1000, 'h6000,  1414};
      tv[10] = '{0,         0,     0,     0, 'h0000,     0};

      i_reset     = 1'b1;
      i_in_valid  = 1'b0;
      i_in_x      = 16'sd0;
      i_in_y      = 16'sd0;
      i_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", {15'd0, o_in_ready}, 16'd0);
      check("rst_start", {15'd0, o_cordic_start}, 16'd0);
      check("rst_out_valid", {15'd0, o_out_valid}, 16'd0);
      check("rst_out_mag", o_out_mag, 16'd0);
      check("rst_out_angle", o_out_angle, 16'd0);
      check("rst_cordic_x", o_cordic_x, 16'd0);
      check("rst_cordic_y", o_cordic_y, 16'd0);
      i_reset = 1'b0;
      @(negedge clk);
      check("rel_in_ready", {15'd0, o_in_ready}, 16'd1);

      // table vectors
      for (int i = 0; i < 11; i++) begin
         run_one(tv[i].x, tv[i].y, tv[i].ex, tv[i].ey, tv[i].eang, tv[i].emag, 0);
      end

      // consumer stalls for 10 cycles
      run_one(-1000, -1000, 1000, 1000, 'hA000, 1414, 10);

      // reset during WAIT, at the cycle where the run counter reads 7
      @(negedge clk);
      i_in_x     = 16'sd1234;
      i_in_y     = -16'sd77;
      i_in_valid = 1'b1;
      ncyc = 0;
      while (!o_in_ready && ncyc < 100) begin
         @(negedge clk);
         ncyc++;
      end
      @(posedge clk);
      #1;
      i_in_valid = 1'b0;
      repeat (7) @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      check("midrst_valid", {15'd0, o_out_valid}, 16'd0);
      check("midrst_start", {15'd0, o_cordic_start}, 16'd0);
      check("midrst_ready", {15'd0, o_in_ready}, 16'd0);
      check("midrst_cx", o_cordic_x, 16'd0);
      i_reset = 1'b0;
      @(negedge clk);
      check("midrst_rel_ready", {15'd0, o_in_ready}, 16'd1);
      run_one(500, 500, 500, 500, 'h2000, 707, 0);

      // back-to-back random stream, consumer always ready
      s0          = starts;
      pushed      = 0;
      popped      = 0;
      last_start  = -1;
      ncyc        = 0;
      i_out_ready = 1'b1;
      while (popped < 50 && ncyc < 1400) begin
         @(negedge clk);
         ncyc++;
         if (o_cordic_start) begin
            if (last_start >= 0) check("start_period", 16'(ncyc - last_start), 16'd20);
            last_start = ncyc;
         end
         if (o_out_valid) begin
            if (qx.size() == 0) begin
               check("unexpected_result", 16'd1, 16'd0);
            end else begin
               rx = qx.pop_front();
               ry = qy.pop_front();
               check("rand_mag", o_out_mag, mag_of(rx, ry));
               check_near("rand_angle", o_out_angle, angle_of(rx, ry));
            end
            popped++;
         end
         if (o_in_ready) begin
            if (pushed < 50) begin
               rx = int'($urandom_range(65534)) - 32767;
               ry = int'($urandom_range(65534)) - 32767;
               i_in_x     = 16'(rx);
               i_in_y     = 16'(ry);
               i_in_valid = 1'b1;
               qx.push_back(rx);
               qy.push_back(ry);
               pushed++;
            end else begin
               i_in_valid = 1'b0;
            end
         end
      end
      i_in_valid = 1'b0;
      check("stream_results", 16'(popped), 16'd50);
      check("stream_starts", 16'(starts - s0), 16'd50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/cordic_sequencer.md
# cordic_sequencer

Initiator side of the iterative CORDIC vectoring core. Accepts (x, y) samples over a valid/ready handshake, folds them into the right half-plane, and issues the one-cycle start pulse the core's controller expects. It then counts out the core's fixed run length, captures magnitude and angle, restores the folded quadrant, and holds the result on an output valid/ready handshake. It sits between the hydrophone phase-pair front end and the USBL phase-difference logic.

## Interface
- DATA_W, 16, signed width of x, y and magnitude
- ANGLE_W, 16, angle width; full scale = 2π, π = 2^(ANGLE_W-1)
- LATENCY, 17, cycles the core's enable is high, counted from and including the start cycle
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  sample offered
- in_ready  out  1  sequencer can accept a sample
- in_x, in_y  in  DATA_W  signed sample
- cordic_start  out  1  one-cycle start pulse to the core controller
- cordic_x, cordic_y  out  DATA_W  folded operands, stable from start until capture
- cordic_mag  in  DATA_W  core magnitude result, passed through unscaled
- cordic_angle  in  ANGLE_W  core angle result, range within ±π/2
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_mag  out  DATA_W  magnitude
- out_angle  out  ANGLE_W  full-circle angle, two's complement modulo 2π

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, register the folded sample and go to START.
  - START: cordic_start=1 for exactly one cycle; clear the counter; go to WAIT.
  - WAIT: counter increments each cycle. When counter == LATENCY-1, go to CAPTURE.
  - CAPTURE: register cordic_mag. Register cordic_angle + offset (mod 2^ANGLE_W). Go to HOLD.
  - HOLD: out_valid=1; outputs stable. On out_ready, go to IDLE.
- Fold rule:
  - x ≥ 0: pass x and y unchanged; offset = 0.
  - x < 0: x' = -x, y' = -y; offset = 2^(ANGLE_W-1), i.e. π.
  - Negating -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
- in_ready is high only in IDLE. No sample is accepted while a run or result is pending.
- in_x and in_y are ignored outside the accepting cycle. cordic_x and cordic_y never change between START and CAPTURE.
- Angle addition wraps and does not saturate.
- Reset values:
  - State IDLE.
  - in_ready=0 during reset, 1 the cycle after reset deasserts.
  - cordic_start=0, out_valid=0.
  - out_mag=0, out_angle=0, cordic_x=0, cordic_y=0, counter=0.
- Reset mid-operation, in any state, returns to IDLE with the reset values above. The core shares the same reset, so no stale result is captured.
- cordic_start is never asserted outside START, so two starts are never issued within one run.

## Timing
- Sample accepted in cycle T, so cordic_start is high in T+1.
- The core's enable covers T+1 … T+LATENCY. The sequencer is in WAIT for the cycles after START through T+LATENCY.
- The core result is valid in T+LATENCY+1. CAPTURE is in T+LATENCY+1.
- out_valid first high in T+LATENCY+2, which is T+19 at defaults.
- out_valid held until an out_ready cycle H. in_ready is high in H+1.
- Minimum sample period with out_ready tied high: LATENCY+3 = 20 cycles.

## Structure
- Shared package cordic_pkg holds:
  - DATA_W, ANGLE_W and LATENCY defaults.
  - ANGLE_PI constant.
  - Sequencer state encoding (IDLE, START, WAIT, CAPTURE, HOLD).
- One sub-module, cordic_prerotate: the combinational fold. Inputs x, y; outputs x', y' and offset, with saturation.
- Counter width is clog2(LATENCY).

## Test plan
- in_x=1000, in_y=0, behavioural core model → cordic_start one pulse at T+1; out_valid at T+19; out_angle=0x0000; out_mag = model value.
- in_x=-1000, in_y=0 → cordic_x=1000, cordic_y=0; out_angle=0x8000.
- in_x=-1000, in_y=-1000, model angle 0x2000 → out_angle=0xA000 (-3π/4); in_x=-32768 → cordic_x=32767.
- out_ready low for 10 cycles after out_valid → out_mag and out_angle stable; in_ready=0; a new in_valid is not accepted until H+1.
- reset asserted during WAIT (counter=7) → next cycle out_valid=0, cordic_start=0, in_ready=1 after release. The next sample completes in exactly 19 cycles.
- Back-to-back in_valid with out_ready=1 → exactly one cordic_start per 20 cycles; no sample lost or duplicated over 50 random samples checked against a reference atan2.
